// File: rtl/pl_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush and an
// optional 2-entry skid buffer; entries leave in FIFO order.
module pl_stage_reg #(
  parameter int DW    = 32,
  parameter int NDATA = 2,
  parameter int RW    = 5,
  parameter int CW    = 2,
  parameter int SKID  = 1
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NDATA*DW-1:0]   in_data,
  input  logic [RW-1:0]         in_rd,
  input  logic [CW-1:0]         in_ctrl,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NDATA*DW-1:0]   out_data,
  output logic [RW-1:0]         out_rd,
  output logic [CW-1:0]         out_ctrl,
  output logic [1:0]            occ
);

  typedef struct packed {
    logic [NDATA*DW-1:0] data;
    logic [RW-1:0]       rd;
    logic [CW-1:0]       ctrl;
  } ent_t;

  ent_t in_ent, head_q, head_d;
  logic hv_q, hv_d;
  logic acc, drain;

  assign in_ent = {in_data, in_rd, in_ctrl};
  assign acc    = in_valid && in_ready;
  assign drain  = hv_q && out_ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      head_q <= '0;
      hv_q   <= 1'b0;
    end else begin
      head_q <= head_d;
      hv_q   <= hv_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      ent_t skid_q, skid_d;
      logic sv_q, sv_d, rdy_q;

      // Flush only drops valid bits; payload registers keep stale contents.
      always_comb begin
        head_d = head_q;
        hv_d   = hv_q;
        skid_d = skid_q;
        sv_d   = sv_q;
        if (flush) begin
          hv_d = 1'b0;
          sv_d = 1'b0;
        end else if (drain) begin
          if (sv_q) begin
            head_d = skid_q;
            sv_d   = 1'b0;
          end else if (acc) begin
            head_d = in_ent;
          end else begin
            hv_d = 1'b0;
          end
        end else if (acc) begin
          if (hv_q) begin
            skid_d = in_ent;
            sv_d   = 1'b1;
          end else begin
            head_d = in_ent;
            hv_d   = 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          skid_q <= '0;
          sv_q   <= 1'b0;
          rdy_q  <= 1'b1;
        end else begin
          skid_q <= skid_d;
          sv_q   <= sv_d;
          rdy_q  <= !sv_d;
        end
      end

      assign in_ready = rdy_q;
      assign occ      = {1'b0, hv_q} + {1'b0, sv_q};
    end else begin : g_single
      always_comb begin
        head_d = head_q;
        hv_d   = hv_q;
        if (flush) begin
          hv_d = 1'b0;
        end else if (acc) begin
          head_d = in_ent;
          hv_d   = 1'b1;
        end else if (drain) begin
          hv_d = 1'b0;
        end
      end

      assign in_ready = !hv_q || out_ready;
      assign occ      = {1'b0, hv_q};
    end
  endgenerate

  assign out_valid = hv_q;
  assign out_data  = head_q.data;
  assign out_rd    = head_q.rd;
  assign out_ctrl  = head_q.ctrl & {CW{hv_q}};

endmodule

// File: tb/tb_pl_stage_reg.sv
// Bench for pl_stage_reg: one SKID=1 and one SKID=0 instance share stimulus;
// a queue model per instance predicts head, occupancy and readiness.
module tb_pl_stage_reg;

  typedef struct packed {
    logic [63:0] d;
    logic [4:0]  rd;
    logic [1:0]  c;
  } ent_t;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [63:0] in_data = '0;
  logic [4:0]  in_rd = '0;
  logic [1:0]  in_ctrl = '0;

  logic        ir1, ov1, ir0, ov0;
  logic [63:0] od1, od0;
  logic [4:0]  ord1, ord0;
  logic [1:0]  oc1, oc0, occ1, occ0;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  pl_stage_reg #(.DW(32), .NDATA(2), .RW(5), .CW(2), .SKID(1)) u_s1 (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_rd(ord1),
    .out_ctrl(oc1), .occ(occ1));

  pl_stage_reg #(.DW(32), .NDATA(2), .RW(5), .CW(2), .SKID(0)) u_s0 (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_rd(ord0),
    .out_ctrl(oc0), .occ(occ0));

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference model: a FIFO of accepted beats, capacity 2 (SKID=1) or 1 (SKID=0).
  ent_t q1[$], q0[$];
  ent_t last1 = '0, last0 = '0;
  ent_t beat;
  bit   acc1, drn1, acc0, drn0;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q1.delete();
      q0.delete();
    end else begin
      beat = '{d: in_data, rd: in_rd, c: in_ctrl};
      acc1 = in_valid && (q1.size() < 2);
      drn1 = (q1.size() > 0) && out_ready;
      acc0 = in_valid && ((q0.size() == 0) || out_ready);
      drn0 = (q0.size() > 0) && out_ready;
      if (flush) q1.delete();
      else begin
        if (drn1) void'(q1.pop_front());
        if (acc1) q1.push_back(beat);
      end
      if (flush) q0.delete();
      else begin
        if (drn0) void'(q0.pop_front());
        if (acc0) q0.push_back(beat);
      end
    end
  end

  task automatic mon(string t, int sz, ent_t hd, ent_t last, bit erdy,
                     logic ov, logic ir, logic [1:0] oc, logic [63:0] od,
                     logic [4:0] ord, logic [1:0] octl);
    chk({t, ".out_valid"}, 64'(ov), 64'(sz > 0));
    chk({t, ".occ"}, 64'(oc), 64'(sz));
    chk({t, ".in_ready"}, 64'(ir), 64'(erdy));
    if (sz > 0) begin
      chk({t, ".out_data"}, od, hd.d);
      chk({t, ".out_rd"}, 64'(ord), 64'(hd.rd));
      chk({t, ".out_ctrl"}, 64'(octl), 64'(hd.c));
    end else begin
      // Empty: payload stays stale, ctrl is gated to a bubble.
      chk({t, ".stale_data"}, od, last.d);
      chk({t, ".stale_rd"}, 64'(ord), 64'(last.rd));
      chk({t, ".bubble_ctrl"}, 64'(octl), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    ent_t h1, h0;
    h1 = '0;
    h0 = '0;
    if (!clrn) begin
      last1 = '0;
      last0 = '0;
    end
    if (q1.size() > 0) h1 = q1[0];
    if (q0.size() > 0) h0 = q0[0];
    mon("s1", q1.size(), h1, last1, q1.size() < 2, ov1, ir1, occ1, od1, ord1, oc1);
    mon("s0", q0.size(), h0, last0, (q0.size() == 0) || out_ready, ov0, ir0, occ0, od0, ord0, oc0);
    if (q1.size() > 0) last1 = h1;
    if (q0.size() > 0) last0 = h0;
  end

  task automatic cyc(bit v, logic [63:0] d, logic [4:0] r, logic [1:0] c, bit fl, bit ordy);
    in_valid  = v;
    in_data   = d;
    in_rd     = r;
    in_ctrl   = c;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic stall_ab();
    cyc(1, 64'hA, 5'd10, 2'b11, 0, 0);
    cyc(1, 64'hB, 5'd11, 2'b11, 0, 0);
    cyc(0, 64'h0, 5'd0, 2'b00, 0, 0);
  endtask

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 3; i++)
      cyc(1'($urandom), {$urandom, $urandom}, 5'($urandom), 2'($urandom), 0, 1'($urandom));
    clrn = 1'b1;
    cyc(1, {32'h11, 32'h22}, 5'd5, 2'b11, 0, 0);
    cyc(0, 64'h0, 5'd0, 2'b00, 0, 1);
    // Streaming.
    for (int i = 0; i < 8; i++)
      cyc(1, 64'h100 + 64'(i), 5'(i), 2'(i), 0, 1);
    cyc(0, 64'h0, 5'd0, 2'b00, 0, 1);
    // Stall then release.
    stall_ab();
    cyc(0, 64'h0, 5'd0, 2'b00, 0, 1);
    cyc(0, 64'h0, 5'd0, 2'b00, 0, 1);
    cyc(0, 64'h0, 5'd0, 2'b00, 0, 1);
    // Flush with a beat presented in the same cycle.
    stall_ab();
    cyc(1, 64'hC, 5'd12, 2'b11, 1, 0);
    cyc(0, 64'h0, 5'd0, 2'b00, 0, 1);
    cyc(0, 64'h0, 5'd0, 2'b00, 0, 1);
    // Asynchronous reset between edges while full.
    stall_ab();
    #1;
    clrn = 1'b0;
    #1;
    chk("async.s1.out_valid", 64'(ov1), 64'd0);
    chk("async.s1.occ", 64'(occ1), 64'd0);
    chk("async.s1.out_ctrl", 64'(oc1), 64'd0);
    chk("async.s0.out_valid", 64'(ov0), 64'd0);
    chk("async.s0.occ", 64'(occ0), 64'd0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 600; i++)
      cyc(($urandom % 4) != 0, {$urandom, $urandom}, 5'($urandom), 2'($urandom),
          ($urandom % 25) == 0, ($urandom % 3) != 0);
    cyc(0, 64'h0, 5'd0, 2'b00, 0, 1);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pl_stage_reg.md
# pl_stage_reg

Parametrised pipeline stage register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries a bundle of datapath words, a destination-register index and control bits between two stages. It adds a valid/ready handshake, stall back-pressure, flush bubble insertion and an optional 2-entry skid buffer. One instance sits at each stage boundary of the RISC-V pipeline; the hazard unit drives `flush`, and the downstream stage drives `out_ready`.

## Interface
- `DW`, 32, width of one datapath word
- `NDATA`, 2, number of datapath words carried (e.g. MEM/WB: memory data, ALU result)
- `RW`, 5, destination register index width
- `CW`, 2, control bit count (e.g. wreg, m2reg)
- `SKID`, 1, 1 = 2-entry skid buffer with registered `in_ready`; 0 = single entry with combinational `in_ready`
- `clk`  in  1  clock, rising edge
- `clrn`  in  1  asynchronous active-low reset
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  block can accept a beat this cycle
- `in_data`  in  NDATA*DW  word k at bits [k*DW +: DW]
- `in_rd`  in  RW  destination register index
- `in_ctrl`  in  CW  control bits
- `flush`  in  1  synchronous kill of all held and presented beats
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  downstream accepts head entry
- `out_data`  out  NDATA*DW  head entry data
- `out_rd`  out  RW  head entry index
- `out_ctrl`  out  CW  head entry control bits, forced 0 when `out_valid`=0
- `occ`  out  2  number of held entries (0..2; max 1 when SKID=0)

## Operation
- Handshake: a beat transfers on a rising edge when valid && ready are both high on that side. The data fields are stable while `out_valid`=1 and `out_ready`=0.
- Storage: a main register (head) and, when SKID=1, a skid register. Entries leave in FIFO order.
- SKID=0: `in_ready` = !out_valid || out_ready. An accept loads the head.
- SKID=1: `in_ready` = !skid_full, taken from a register.
  - If a beat is accepted while the head is held (out_valid && !out_ready), the beat goes to the skid register.
  - If the head drains while the skid register is full, the skid entry moves to the head on the same edge.
  - If the head drains while the skid register is empty and a beat is accepted, the beat loads the head directly.
- Bubble rule: `out_ctrl` = stored ctrl & {CW{out_valid}}. A bubble can never assert register-file write.
- Flush: on the edge where `flush`=1:
  - the valid bits of all entries clear and `occ` becomes 0;
  - any beat handshaken in that same cycle is discarded;
  - `out_data` and `out_rd` keep their stale values;
  - `out_ctrl` reads 0 from the next cycle.
- Flush has priority over every accept and drain in that cycle.
- `occ` = head_valid + skid_valid.

## Timing
- Reset (clrn=0, asynchronous): `out_valid`=0, `out_data`=0, `out_rd`=0, `out_ctrl`=0, `occ`=0, skid storage=0. `in_ready` is 1 for both SKID settings (for SKID=0 it follows from `out_valid`=0).
- A reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency: a beat accepted at edge N appears on the `out_*` outputs after edge N, provided the head was empty or draining.
- Throughput: one beat per cycle sustained, for both SKID settings, while `out_ready`=1.
- SKID=1 under a stall: two beats can be absorbed. After the second absorbed beat, `in_ready` falls on the next edge.
- SKID=1, skid register full, and `out_ready` rises: on that edge the head drains, the skid entry moves to the head and `in_ready` returns to 1. No beat is accepted on that edge, because `in_ready` was 0.
- Simultaneous drain and accept when SKID=1 and occ=1: occ stays 1 and the new beat becomes the head.
- Flush and reset affect only the valid bits and state. No other field is cleared by flush.

## Test plan
- Reset: hold clrn=0 with random inputs -> `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occ`=0, `in_ready`=1. Release reset and present in_data={0x11,0x22}, rd=5, ctrl=2'b11 -> the next cycle shows out_valid=1 with those values.
- Streaming: 8 beats, data 0x100+i, with out_ready=1 -> 8 outputs in order, one per cycle, no gaps, for both SKID=0 and SKID=1.
- Stall, SKID=1: out_ready=0 while beats A=0xA and B=0xB are sent -> occ=2, in_ready=0, out_data holds A. Raise out_ready -> A, then B on consecutive cycles, and in_ready=1 again.
- Flush: with occ=2 and in_valid=1 carrying C, pulse flush for 1 cycle -> the next cycle has out_valid=0, out_ctrl=0, occ=0, and C never appears.
- Bubble gating: stored ctrl=2'b11 with out_valid=0 after a flush -> out_ctrl=2'b00 while out_rd keeps its stale value.
- Async reset mid-stall: assert clrn=0 between clock edges with occ=2 -> out_valid=0 and occ=0 immediately, before the next edge.
